reorder_buffer: RTL and testbench

8-entry in-order reorder buffer that answers the rename stage's allocation requests, collects execution results, and retires one instruction per cycle towards the architectural register file. It allocates up to two entries per cycle and returns a ticket plus full/two-empty status to the issue side. It records completions from EX and emits `writeback_toARF` commits, including flushed entries, so rename can free or restore physical registers.

---
 rtl/reorder_buffer_pkg.sv | 76 +++++++
 rtl/reorder_buffer_flush_mask.sv | 24 ++
 rtl/reorder_buffer.sv | 163 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer and its helpers.
package reorder_buffer_pkg;

  localparam int unsigned ROB_INDEX_BITS = 3;
  localparam int unsigned ROB_DEPTH      = 2 ** ROB_INDEX_BITS;
  localparam int unsigned P_ADDR_WIDTH   = 6;
  localparam int unsigned L_ADDR_WIDTH   = 5;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned PC_WIDTH       = 32;
  localparam int unsigned UOP_WIDTH      = 6;
  localparam int unsigned CAUSE_WIDTH    = 5;

  // Up to two allocation requests from rename, oldest in slot 1.
  typedef struct packed {
    logic                      valid_request_1;
    logic                      valid_dest_1;
    logic [L_ADDR_WIDTH-1:0]   lreg_1;
    logic [P_ADDR_WIDTH-1:0]   preg_1;
    logic [P_ADDR_WIDTH-1:0]   ppreg_1;
    logic [UOP_WIDTH-1:0]      microoperation_1;
    logic [PC_WIDTH-1:0]       pc_1;
    logic                      valid_request_2;
    logic                      valid_dest_2;
    logic [L_ADDR_WIDTH-1:0]   lreg_2;
    logic [P_ADDR_WIDTH-1:0]   preg_2;
    logic [P_ADDR_WIDTH-1:0]   ppreg_2;
    logic [UOP_WIDTH-1:0]      microoperation_2;
    logic [PC_WIDTH-1:0]       pc_2;
  } new_entries;

  // Occupancy status and next ticket returned to issue.
  typedef struct packed {
    logic                      is_full;
    logic                      two_empty;
    logic [ROB_INDEX_BITS-1:0] ticket;
  } to_issue;

  // Completion report from execute.
  typedef struct packed {
    logic                      valid;
    logic [ROB_INDEX_BITS-1:0] ticket;
    logic [DATA_WIDTH-1:0]     data;
    logic                      valid_exception;
    logic [CAUSE_WIDTH-1:0]    cause;
  } ex_update;

  // Retirement record towards the architectural register file.
  typedef struct packed {
    logic                      valid_commit;
    logic                      valid_write;
    logic                      flushed;
    logic [L_ADDR_WIDTH-1:0]   ldst;
    logic [P_ADDR_WIDTH-1:0]   pdst;
    logic [P_ADDR_WIDTH-1:0]   ppdst;
    logic [DATA_WIDTH-1:0]     data;
    logic [ROB_INDEX_BITS-1:0] ticket;
    logic [PC_WIDTH-1:0]       pc;
  } writeback_toARF;

  // One in-flight instruction.
  typedef struct packed {
    logic                      valid;
    logic                      pending;
    logic                      flushed;
    logic                      valid_dest;
    logic [L_ADDR_WIDTH-1:0]   lreg;
    logic [P_ADDR_WIDTH-1:0]   preg;
    logic [P_ADDR_WIDTH-1:0]   ppreg;
    logic [UOP_WIDTH-1:0]      microoperation;
    logic [PC_WIDTH-1:0]       pc;
    logic [DATA_WIDTH-1:0]     data;
    logic                      valid_exception;
    logic [CAUSE_WIDTH-1:0]    cause;
  } rob_entry;

endpackage

// File: rtl/reorder_buffer_flush_mask.sv
// Marks valid entries strictly younger than a flush ticket, ages taken from head.
module rob_flush_mask
  import reorder_buffer_pkg::*;
(
  input  logic [ROB_INDEX_BITS-1:0] head_i,
  input  logic [ROB_INDEX_BITS-1:0] flush_ticket_i,
  input  logic [ROB_DEPTH-1:0]      valid_i,
  output logic [ROB_DEPTH-1:0]      younger_o
);

  // Compare each slot's age against the flush point's age (both modulo depth).
  always_comb begin
    logic [ROB_INDEX_BITS-1:0] flush_age;
    logic [ROB_INDEX_BITS-1:0] age;
    younger_o = '0;
    age       = '0;
    flush_age = flush_ticket_i - head_i;
    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      age          = ROB_INDEX_BITS'(i) - head_i;
      younger_o[i] = valid_i[i] && (age > flush_age);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// 8-entry in-order reorder buffer: dual allocation, out-of-order completion,
// single in-order retirement with flush and exception squashing.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  new_entries                new_entries_i,
  output to_issue                   rob_status_o,
  input  ex_update                  ex_update_i,
  input  logic                      flush_valid_i,
  input  logic [ROB_INDEX_BITS-1:0] flush_ticket_i,
  output writeback_toARF            commit_o
);

  localparam logic [ROB_INDEX_BITS:0] CNT_FULL      = (ROB_INDEX_BITS+1)'(ROB_DEPTH);
  localparam logic [ROB_INDEX_BITS:0] CNT_TWO_EMPTY = (ROB_INDEX_BITS+1)'(ROB_DEPTH - 2);

  rob_entry                  entries_q [ROB_DEPTH];
  rob_entry                  entries_d [ROB_DEPTH];
  logic [ROB_INDEX_BITS-1:0] head_q, head_d;
  logic [ROB_INDEX_BITS-1:0] tail_q, tail_d;
  logic [ROB_INDEX_BITS:0]   count_q, count_d;
  writeback_toARF            commit_q, commit_d;

  logic                      is_full, two_empty;
  logic                      alloc1, alloc2;
  logic                      do_commit, exc_commit;
  logic [ROB_INDEX_BITS-1:0] slot2;
  logic [ROB_DEPTH-1:0]      valid_vec;
  logic [ROB_DEPTH-1:0]      younger;

  // Status is derived from registered occupancy only.
  always_comb begin
    is_full      = (count_q == CNT_FULL);
    two_empty    = (count_q <= CNT_TWO_EMPTY);
    rob_status_o = '{is_full: is_full, two_empty: two_empty, ticket: tail_q};
  end

  // Gather the valid bits for the flush mask.
  always_comb begin
    valid_vec = '0;
    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      valid_vec[i] = entries_q[i].valid;
    end
  end

  rob_flush_mask u_flush_mask (
    .head_i         (head_q),
    .flush_ticket_i (flush_ticket_i),
    .valid_i        (valid_vec),
    .younger_o      (younger)
  );

  // Next-state: completion, flush/exception squash, retirement, then allocation.
  always_comb begin
    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      entries_d[i] = entries_q[i];
    end
    commit_d   = '0;
    head_d     = head_q;
    slot2      = tail_q + ROB_INDEX_BITS'(1);
    alloc1     = new_entries_i.valid_request_1 && !is_full;
    alloc2     = new_entries_i.valid_request_2 && new_entries_i.valid_request_1 && two_empty;
    do_commit  = entries_q[head_q].valid &&
                 (!entries_q[head_q].pending || entries_q[head_q].flushed);
    exc_commit = do_commit && entries_q[head_q].valid_exception;

    if (ex_update_i.valid && entries_q[ex_update_i.ticket].valid) begin
      entries_d[ex_update_i.ticket].pending         = 1'b0;
      entries_d[ex_update_i.ticket].data            = ex_update_i.data;
      entries_d[ex_update_i.ticket].valid_exception = ex_update_i.valid_exception;
      entries_d[ex_update_i.ticket].cause           = ex_update_i.cause;
    end

    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      if (flush_valid_i && younger[i]) begin
        entries_d[i].flushed = 1'b1;
      end
      if (exc_commit && entries_q[i].valid && (ROB_INDEX_BITS'(i) != head_q)) begin
        entries_d[i].flushed = 1'b1;
      end
    end

    if (do_commit) begin
      commit_d.valid_commit = 1'b1;
      commit_d.flushed      = entries_q[head_q].flushed;
      commit_d.valid_write  = entries_q[head_q].valid_dest && !entries_q[head_q].flushed &&
                              !entries_q[head_q].valid_exception;
      commit_d.ldst         = entries_q[head_q].lreg;
      commit_d.pdst         = entries_q[head_q].preg;
      commit_d.ppdst        = entries_q[head_q].ppreg;
      commit_d.data         = entries_q[head_q].data;
      commit_d.ticket       = head_q;
      commit_d.pc           = entries_q[head_q].pc;
      entries_d[head_q].valid = 1'b0;
      head_d                = head_q + ROB_INDEX_BITS'(1);
    end

    // Allocated slots are always free here: a full buffer never allocates,
    // so the slot being retired can never be re-targeted in the same cycle.
    if (alloc1) begin
      entries_d[tail_q] = '{
        valid:           1'b1,
        pending:         1'b1,
        flushed:         flush_valid_i || exc_commit,
        valid_dest:      new_entries_i.valid_dest_1,
        lreg:            new_entries_i.lreg_1,
        preg:            new_entries_i.preg_1,
        ppreg:           new_entries_i.ppreg_1,
        microoperation:  new_entries_i.microoperation_1,
        pc:              new_entries_i.pc_1,
        data:            '0,
        valid_exception: 1'b0,
        cause:           '0
      };
    end
    if (alloc2) begin
      entries_d[slot2] = '{
        valid:           1'b1,
        pending:         1'b1,
        flushed:         flush_valid_i || exc_commit,
        valid_dest:      new_entries_i.valid_dest_2,
        lreg:            new_entries_i.lreg_2,
        preg:            new_entries_i.preg_2,
        ppreg:           new_entries_i.ppreg_2,
        microoperation:  new_entries_i.microoperation_2,
        pc:              new_entries_i.pc_2,
        data:            '0,
        valid_exception: 1'b0,
        cause:           '0
      };
    end

    tail_d  = tail_q + ROB_INDEX_BITS'(alloc1) + ROB_INDEX_BITS'(alloc2);
    count_d = count_q + (ROB_INDEX_BITS+1)'(alloc1) + (ROB_INDEX_BITS+1)'(alloc2)
                      - (ROB_INDEX_BITS+1)'(do_commit);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      commit_q <= '0;
    end else begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      commit_q <= commit_d;
    end
  end

  assign commit_o = commit_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer against a queue-based
// program-order model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  new_entries     ne;
  to_issue        st;
  ex_update       ex;
  logic           fv;
  logic [2:0]     ft;
  writeback_toARF cm;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .new_entries_i  (ne),
    .rob_status_o   (st),
    .ex_update_i    (ex),
    .flush_valid_i  (fv),
    .flush_ticket_i (ft),
    .commit_o       (cm)
  );

  typedef struct {
    int unsigned ticket;
    logic        vd;
    logic [4:0]  lreg;
    logic [5:0]  preg;
    logic [5:0]  ppreg;
    logic [31:0] pc;
    logic [31:0] data;
    bit          done;
    bit          exc;
    bit          flushed;
  } mentry_t;

  mentry_t        q[$];
  int unsigned    m_head = 0;
  writeback_toARF exp_cm = '0;
  bit             exp_data_known = 0;
  int             n_cmp = 0;
  int             n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] pk(input writeback_toARF c);
    return {c.valid_commit, c.valid_write, c.flushed, c.ldst, c.pdst, c.ppdst, c.ticket, c.pc};
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int unsigned sz, tl, fa;
    bit          do_c, exc_c;
    mentry_t     e;
    if (!rst_n) begin
      q.delete();
      m_head = 0;
      exp_cm = '0;
      exp_data_known = 0;
      return;
    end
    sz = q.size();
    tl = (m_head + sz) % 8;
    exp_cm = '0;
    exp_data_known = 0;
    do_c = 0;
    exc_c = 0;
    if (sz > 0 && (q[0].done || q[0].flushed)) begin
      do_c = 1;
      exc_c = q[0].exc;
      exp_cm.valid_commit = 1'b1;
      exp_cm.flushed      = q[0].flushed;
      exp_cm.valid_write  = q[0].vd && !q[0].flushed && !q[0].exc;
      exp_cm.ldst         = q[0].lreg;
      exp_cm.pdst         = q[0].preg;
      exp_cm.ppdst        = q[0].ppreg;
      exp_cm.ticket       = 3'(q[0].ticket);
      exp_cm.pc           = q[0].pc;
      exp_cm.data         = q[0].data;
      exp_data_known      = q[0].done;
    end
    if (ex.valid) begin
      foreach (q[i]) if (q[i].ticket == int'(ex.ticket)) begin
        q[i].done = 1;
        q[i].data = ex.data;
        q[i].exc  = ex.valid_exception;
      end
    end
    if (fv) begin
      fa = (int'(ft) + 8 - m_head) % 8;
      foreach (q[i]) if (i > int'(fa)) q[i].flushed = 1;
    end
    if (exc_c) foreach (q[i]) if (i > 0) q[i].flushed = 1;
    if (do_c) begin
      void'(q.pop_front());
      m_head = (m_head + 1) % 8;
    end
    if (ne.valid_request_1 && sz < 8) begin
      e = '{ticket: tl, vd: ne.valid_dest_1, lreg: ne.lreg_1, preg: ne.preg_1, ppreg: ne.ppreg_1,
            pc: ne.pc_1, data: 32'h0, done: 0, exc: 0, flushed: fv || exc_c};
      q.push_back(e);
      if (ne.valid_request_2 && sz <= 6) begin
        e = '{ticket: (tl + 1) % 8, vd: ne.valid_dest_2, lreg: ne.lreg_2, preg: ne.preg_2,
              ppreg: ne.ppreg_2, pc: ne.pc_2, data: 32'h0, done: 0, exc: 0,
              flushed: fv || exc_c};
        q.push_back(e);
      end
    end
  endtask

  task automatic check_outputs();
    int unsigned sz;
    sz = q.size();
    check("status", {st.is_full, st.two_empty, st.ticket},
          {(sz == 8), (sz <= 6), 3'((m_head + sz) % 8)});
    check("commit", pk(cm), pk(exp_cm));
    if (exp_cm.valid_commit && exp_data_known) check("commit_data", cm.data, exp_cm.data);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    ne = '0;
    ex = '0;
    fv = 1'b0;
    ft = 3'd0;
  endtask

  task automatic req(input int n);
    ne.valid_request_1  = (n >= 1);
    ne.valid_dest_1     = 1'($urandom);
    ne.lreg_1           = 5'($urandom);
    ne.preg_1           = 6'($urandom);
    ne.ppreg_1          = 6'($urandom);
    ne.microoperation_1 = 6'($urandom);
    ne.pc_1             = $urandom;
    ne.valid_request_2  = (n >= 2);
    ne.valid_dest_2     = 1'($urandom);
    ne.lreg_2           = 5'($urandom);
    ne.preg_2           = 6'($urandom);
    ne.ppreg_2          = 6'($urandom);
    ne.microoperation_2 = 6'($urandom);
    ne.pc_2             = $urandom;
  endtask

  task automatic exu(input int t, input bit e);
    ex.valid           = 1'b1;
    ex.ticket          = 3'(t);
    ex.data            = $urandom;
    ex.valid_exception = e;
    ex.cause           = 5'($urandom);
  endtask

  task automatic run_idle(input int n);
    repeat (n) begin
      idle();
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  int order[7] = '{3, 1, 2, 4, 5, 6, 7};

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    do_reset();

    // Fill with pairs, then offer while full and complete ticket 0.
    repeat (4) begin idle(); req(2); tick(); end
    idle(); req(1); exu(0, 0); tick();
    run_idle(3);
    foreach (order[k]) begin idle(); exu(order[k], 0); tick(); end
    run_idle(10);

    // Branch flush with head=0, six entries, flush ticket 2.
    do_reset();
    repeat (3) begin idle(); req(2); tick(); end
    idle(); fv = 1'b1; ft = 3'd2; tick();
    run_idle(4);
    for (int t = 0; t < 3; t++) begin idle(); exu(t, 0); tick(); end
    run_idle(8);

    // Head wrap: drain six, then 6,7,0,1 in flight and flush after 7.
    do_reset();
    repeat (3) begin idle(); req(2); tick(); end
    for (int t = 0; t < 6; t++) begin idle(); exu(t, 0); tick(); end
    run_idle(6);
    repeat (2) begin idle(); req(2); tick(); end
    idle(); fv = 1'b1; ft = 3'd7; tick();
    idle(); exu(6, 0); tick();
    idle(); exu(7, 0); tick();
    run_idle(8);

    // Exception on ticket 1 squashes pending ticket 2.
    do_reset();
    idle(); req(2); tick();
    idle(); req(1); tick();
    idle(); exu(0, 0); tick();
    idle(); exu(1, 1); tick();
    run_idle(8);

    // Random traffic with occasional flushes and mid-run resets.
    for (int c = 0; c < 4000; c++) begin
      idle();
      rst_n = ($urandom_range(0, 299) != 0);
      req($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          exu(int'(q[$urandom_range(0, q.size() - 1)].ticket), $urandom_range(0, 15) == 0);
        else
          exu($urandom_range(0, 7), $urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 39) == 0) begin
        fv = 1'b1;
        ft = 3'($urandom);
      end
      tick();
    end
    rst_n = 1'b1;
    run_idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
